// File: rtl/fft_cmul_round_sat.sv
// Complex-multiply combine stage: re/im sums of twiddle partial products, round half up, saturate.
// Define FFT_CMUL_OVF_CNT_EN to build the saturation event counter on ovf_count.
module fft_cmul_round_sat #(
  parameter int PROD_WIDTH = 39,
  parameter int OUT_WIDTH  = 24,
  parameter int FRAC_SHIFT = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        s_last,
  input  logic signed [PROD_WIDTH-1:0] p_rr,
  input  logic signed [PROD_WIDTH-1:0] p_ii,
  input  logic signed [PROD_WIDTH-1:0] p_ri,
  input  logic signed [PROD_WIDTH-1:0] p_ir,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_last,
  output logic signed [OUT_WIDTH-1:0] m_re,
  output logic signed [OUT_WIDTH-1:0] m_im,
  output logic                        m_sat,
  output logic [15:0]                 ovf_count
);

  localparam int SW = PROD_WIDTH + 1;
  localparam int RW = SW + 1;
  localparam logic signed [RW-1:0] HALF = {{(RW-1){1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
  localparam logic signed [RW-1:0] MAXV = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic                        v1;
  logic                        v2;
  logic                        last1;
  logic                        en1;
  logic                        en2;
  logic signed [SW-1:0]        sr;
  logic signed [SW-1:0]        si;
  logic signed [OUT_WIDTH-1:0] re_n;
  logic signed [OUT_WIDTH-1:0] im_n;
  logic                        re_sat;
  logic                        im_sat;

  // Extra headroom bit keeps the rounding add from wrapping at the extremes.
  function automatic logic [OUT_WIDTH:0] round_sat(input logic signed [SW-1:0] x);
    logic signed [RW-1:0] w;
    logic [OUT_WIDTH:0]   res;
    w = $signed({x[SW-1], x}) + HALF;
    w = w >>> FRAC_SHIFT;
    if (w > MAXV)
      res = {1'b1, MAXV[OUT_WIDTH-1:0]};
    else if (w < MINV)
      res = {1'b1, MINV[OUT_WIDTH-1:0]};
    else
      res = {1'b0, w[OUT_WIDTH-1:0]};
    return res;
  endfunction

  assign en2     = !v2 || m_ready;
  assign en1     = !v1 || en2;
  assign s_ready = en1;
  assign m_valid = v2;

  always_comb begin
    {re_sat, re_n} = round_sat(sr);
    {im_sat, im_n} = round_sat(si);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1    <= 1'b0;
      last1 <= 1'b0;
      sr    <= '0;
      si    <= '0;
    end else if (en1) begin
      v1 <= s_valid;
      if (s_valid) begin
        sr    <= $signed({p_rr[PROD_WIDTH-1], p_rr}) - $signed({p_ii[PROD_WIDTH-1], p_ii});
        si    <= $signed({p_ri[PROD_WIDTH-1], p_ri}) + $signed({p_ir[PROD_WIDTH-1], p_ir});
        last1 <= s_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v2     <= 1'b0;
      m_last <= 1'b0;
      m_sat  <= 1'b0;
      m_re   <= '0;
      m_im   <= '0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        m_re   <= re_n;
        m_im   <= im_n;
        m_sat  <= re_sat || im_sat;
        m_last <= last1;
      end
    end
  end

`ifdef FFT_CMUL_OVF_CNT_EN
  // Counts saturated outputs actually delivered downstream; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset)
      ovf_count <= '0;
    else if (v2 && m_ready && m_sat && (ovf_count != 16'hFFFF))
      ovf_count <= ovf_count + 16'd1;
  end
`else
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_fft_cmul_round_sat.sv
// Self-checking bench for fft_cmul_round_sat: arithmetic reference model plus directed vectors.
module tb_fft_cmul_round_sat;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic               s_last = 1'b0;
  logic signed [38:0] p_rr = '0;
  logic signed [38:0] p_ii = '0;
  logic signed [38:0] p_ri = '0;
  logic signed [38:0] p_ir = '0;
  logic               m_valid;
  logic               m_ready = 1'b1;
  logic               m_last;
  logic signed [23:0] m_re;
  logic signed [23:0] m_im;
  logic               m_sat;
  logic [15:0]        ovf_count;

  typedef struct {
    longint re;
    longint im;
    bit     sat;
    bit     last;
  } exp_t;

  exp_t   expQ[$];
  int     tests = 0;
  int     fails = 0;
  int     outCount = 0;
  int     lastPos = 0;
  int     lastCount = 0;
  longint modelOvf = 0;
  bit     prevStall = 0;
  longint prevRe, prevIm;
  bit     prevSat, prevLast;

`ifdef FFT_CMUL_OVF_CNT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  fft_cmul_round_sat dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .p_rr(p_rr), .p_ii(p_ii), .p_ri(p_ri), .p_ir(p_ir),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .m_re(m_re), .m_im(m_im), .m_sat(m_sat), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference: exact sum, floor((s + 2^14) / 2^15), clamp to 24-bit signed range.
  function automatic void model(input longint s, output longint res, output bit sat);
    longint q, r;
    q = s + 16384;
    r = q / 32768;
    if ((q % 32768 != 0) && (q < 0)) r = r - 1;
    sat = 1'b0;
    res = r;
    if (r > 8388607) begin
      res = 8388607;
      sat = 1'b1;
    end else if (r < -8388608) begin
      res = -8388608;
      sat = 1'b1;
    end
  endfunction

  // Scoreboard and protocol checks, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    bit   rs, is;
    if (reset) begin
      expQ.delete();
      modelOvf  = 0;
      prevStall = 0;
    end else begin
      if (prevStall) begin
        checkOutput("stall_valid", m_valid, 1);
        checkOutput("stall_re", m_re, prevRe);
        checkOutput("stall_im", m_im, prevIm);
        checkOutput("stall_sat", m_sat, prevSat);
        checkOutput("stall_last", m_last, prevLast);
      end
      checkOutput("ovf_count", ovf_count, modelOvf);
      if (m_ready) checkOutput("s_ready_when_m_ready", s_ready, 1);
      if (!m_valid) checkOutput("s_ready_when_out_empty", s_ready, 1);
      if (m_valid && m_ready) begin
        outCount++;
        if (m_last) begin
          lastPos = outCount;
          lastCount++;
        end
        if (expQ.size() == 0) begin
          checkOutput("unexpected_output", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("model_re", m_re, e.re);
          checkOutput("model_im", m_im, e.im);
          checkOutput("model_sat", m_sat, e.sat);
          checkOutput("model_last", m_last, e.last);
          if (OVF_EN && e.sat && modelOvf < 65535) modelOvf++;
        end
      end
      if (s_valid && s_ready) begin
        model(longint'(p_rr) - longint'(p_ii), e.re, rs);
        model(longint'(p_ri) + longint'(p_ir), e.im, is);
        e.sat  = rs || is;
        e.last = s_last;
        expQ.push_back(e);
      end
      prevStall = m_valid && !m_ready;
      prevRe    = m_re;
      prevIm    = m_im;
      prevSat   = m_sat;
      prevLast  = m_last;
    end
  end

  task automatic applyStimulus(input longint rr, input longint ii, input longint ri,
                               input longint ir, input bit last);
    p_rr    = rr[38:0];
    p_ii    = ii[38:0];
    p_ri    = ri[38:0];
    p_ir    = ir[38:0];
    s_last  = last;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic runVector(input string name, input longint rr, input longint ii,
                           input longint ri, input longint ir,
                           input longint expRe, input longint expIm, input bit expSat);
    applyStimulus(rr, ii, ri, ir, 1'b0);
    @(negedge clk);
    checkOutput({name, "_not_yet"}, m_valid, 0);
    @(negedge clk);
    checkOutput({name, "_valid"}, m_valid, 1);
    checkOutput({name, "_re"}, m_re, expRe);
    checkOutput({name, "_im"}, m_im, expIm);
    checkOutput({name, "_sat"}, m_sat, expSat);
  endtask

  task automatic runStream(input string name, input int n, input logic [3:0] pat, input int lastAt);
    int idx = 0;
    int cyc = 0;
    int startCount = outCount;
    bit acc = 0;
    while (((outCount - startCount) < n) && (cyc < 300)) begin
      @(posedge clk);
      if (acc) idx++;
      #1;
      m_ready = pat[cyc % 4];
      s_valid = (idx < n);
      p_rr    = 39'(longint'(idx + 1) * 32768);
      p_ii    = '0;
      p_ri    = '0;
      p_ir    = '0;
      s_last  = ((idx + 1) == lastAt);
      @(negedge clk);
      acc = s_valid && s_ready;
      cyc++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    checkOutput({name, "_outputs"}, outCount - startCount, n);
    @(negedge clk);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_m_valid", m_valid, 0);
    checkOutput("reset_m_re", m_re, 0);
    checkOutput("reset_m_im", m_im, 0);
    checkOutput("reset_m_last", m_last, 0);
    checkOutput("reset_m_sat", m_sat, 0);
    checkOutput("reset_ovf", ovf_count, 0);
    checkOutput("reset_s_ready", s_ready, 1);

    runVector("scale", 16384000, 0, 0, 8192000, 500, 250, 0);
    runVector("rnd_p49152", 49152, 0, 0, 0, 2, 0, 0);
    runVector("rnd_m49152", -49152, 0, 0, 0, -1, 0, 0);
    runVector("rnd_16383", 16383, 0, 0, 0, 0, 0, 0);
    runVector("rnd_16384", 16384, 0, 0, 0, 1, 0, 0);
    runVector("im_sum", 0, 0, 3 * 32768, -(5 * 32768), 0, -2, 0);
    runVector("sat_pos", (longint'(1) << 38) - 1, -(longint'(1) << 38), 0, 0, 8388607, 0, 1);
    runVector("sat_neg", -(longint'(1) << 38), (longint'(1) << 38) - 1, 0, 0, -8388608, 0, 1);
    @(negedge clk);
    checkOutput("ovf_after_sat", ovf_count, OVF_EN ? 2 : 0);

    runStream("backpressure", 8, 4'b1001, 0);

    lastPos   = 0;
    lastCount = 0;
    base      = outCount;
    runStream("frame", 4, 4'b1111, 4);
    checkOutput("frame_last_count", lastCount, 1);
    checkOutput("frame_last_pos", lastPos - base, 4);

    // Fill both stages under backpressure, then reset with two samples in flight.
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    s_valid = 1'b1;
    p_rr    = 39'(5 * 32768);
    @(posedge clk);
    #1;
    p_rr = 39'(6 * 32768);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    @(negedge clk);
    checkOutput("full_m_valid", m_valid, 1);
    checkOutput("full_s_ready", s_ready, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_m_valid", m_valid, 0);
    checkOutput("midrst_s_ready", s_ready, 1);
    checkOutput("midrst_ovf", ovf_count, 0);
    m_ready = 1'b1;
    runVector("after_reset", 7 * 32768, 0, 0, 0, 7, 0, 0);
    repeat (3) @(negedge clk);
    checkOutput("drained", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
